// File: rtl/rv32i_pkg.sv
// Shared types and funct3 encodings for the RV32I writeback stage.
package rv32i_pkg;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_IO   = 2'd2,
        SRC_LINK = 2'd3
    } src_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/rv32i_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of a read word and extends it.
module rv32i_load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // offset[0] is ignored for halfwords; misalignment is not trapped here
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0, half_sel};
            F3_LW:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_wb_top.sv
// RV32I writeback stage: MEM/WB register, load alignment, source mux, x0 gating, instret counter.
module rv32i_wb_top
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_in,
    input  logic                 valid_in,
    input  logic [31:0]          pc_in,
    input  logic [31:0]          iw_in,
    input  logic [31:0]          alu_in,
    input  logic [4:0]           wb_reg_in,
    input  logic                 wb_en_in,
    input  logic [1:0]           src_sel_in,
    input  logic [31:0]          memif_rdata,
    input  logic [31:0]          io_rdata,
    output logic                 regif_wb_enable,
    output logic [4:0]           regif_wb_reg,
    output logic [31:0]          regif_wb_data,
    output logic                 df_wb_enable,
    output logic [4:0]           df_wb_reg,
    output logic [31:0]          df_wb_data,
    output logic [INSTRET_W-1:0] instret_count
);

    logic [31:0]          pc_q,      pc_d;
    logic [31:0]          iw_q,      iw_d;
    logic [31:0]          alu_q,     alu_d;
    logic [4:0]           wb_reg_q,  wb_reg_d;
    logic                 wb_en_q,   wb_en_d;
    src_sel_t             src_sel_q, src_sel_d;
    logic                 valid_q,   valid_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    logic [31:0] mem_aligned;
    logic [31:0] io_aligned;
    logic [31:0] wb_data;
    logic        wb_enable;
    logic        unused_iw_bits;

    always_comb begin
        pc_d      = pc_q;
        iw_d      = iw_q;
        alu_d     = alu_q;
        wb_reg_d  = wb_reg_q;
        wb_en_d   = wb_en_q;
        src_sel_d = src_sel_q;
        valid_d   = valid_q;
        instret_d = instret_q;
        if (!stall_in) begin
            pc_d      = pc_in;
            iw_d      = iw_in;
            alu_d     = alu_in;
            wb_reg_d  = wb_reg_in;
            wb_en_d   = wb_en_in;
            src_sel_d = src_sel_t'(src_sel_in);
            valid_d   = valid_in;
        end
        // a stalled instruction is counted only on the cycle it leaves WB
        if (valid_q && !stall_in) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            iw_q      <= '0;
            alu_q     <= '0;
            wb_reg_q  <= '0;
            wb_en_q   <= 1'b0;
            src_sel_q <= SRC_ALU;
            valid_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            pc_q      <= pc_d;
            iw_q      <= iw_d;
            alu_q     <= alu_d;
            wb_reg_q  <= wb_reg_d;
            wb_en_q   <= wb_en_d;
            src_sel_q <= src_sel_d;
            valid_q   <= valid_d;
            instret_q <= instret_d;
        end
    end

    rv32i_load_align u_align_mem (
        .rdata  (memif_rdata),
        .offset (alu_q[1:0]),
        .funct3 (iw_q[14:12]),
        .data   (mem_aligned)
    );

    rv32i_load_align u_align_io (
        .rdata  (io_rdata),
        .offset (alu_q[1:0]),
        .funct3 (iw_q[14:12]),
        .data   (io_aligned)
    );

    always_comb begin
        wb_data = alu_q;
        case (src_sel_q)
            SRC_ALU:  wb_data = alu_q;
            SRC_MEM:  wb_data = mem_aligned;
            SRC_IO:   wb_data = io_aligned;
            SRC_LINK: wb_data = pc_q + 32'd4;
            default:  wb_data = alu_q;
        endcase
    end

    assign wb_enable = valid_q & wb_en_q & (wb_reg_q != 5'd0);

    assign regif_wb_enable = wb_enable;
    assign regif_wb_reg    = wb_reg_q;
    assign regif_wb_data   = wb_data;
    assign df_wb_enable    = wb_enable;
    assign df_wb_reg       = wb_reg_q;
    assign df_wb_data      = wb_data;
    assign instret_count   = instret_q;

    // only funct3 of the instruction word matters in this stage
    assign unused_iw_bits = ^{iw_q[31:15], iw_q[11:0]};

endmodule

// File: tb/tb_rv32i_wb_top.sv
// Directed self-checking bench for rv32i_wb_top, with a narrow-counter instance for wrap checks.
module tb_rv32i_wb_top;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        valid_in;
    logic [31:0] pc_in;
    logic [31:0] iw_in;
    logic [31:0] alu_in;
    logic [4:0]  wb_reg_in;
    logic        wb_en_in;
    logic [1:0]  src_sel_in;
    logic [31:0] memif_rdata;
    logic [31:0] io_rdata;

    logic        regif_wb_enable;
    logic [4:0]  regif_wb_reg;
    logic [31:0] regif_wb_data;
    logic        df_wb_enable;
    logic [4:0]  df_wb_reg;
    logic [31:0] df_wb_data;
    logic [63:0] instret_count;

    logic        s_regif_wb_enable;
    logic [4:0]  s_regif_wb_reg;
    logic [31:0] s_regif_wb_data;
    logic        s_df_wb_enable;
    logic [4:0]  s_df_wb_reg;
    logic [31:0] s_df_wb_data;
    logic [2:0]  s_instret_count;

    int checks = 0;
    int errors = 0;

    rv32i_wb_top #(.RESET_PC(32'h0000_0100), .INSTRET_W(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_in        (stall_in),
        .valid_in        (valid_in),
        .pc_in           (pc_in),
        .iw_in           (iw_in),
        .alu_in          (alu_in),
        .wb_reg_in       (wb_reg_in),
        .wb_en_in        (wb_en_in),
        .src_sel_in      (src_sel_in),
        .memif_rdata     (memif_rdata),
        .io_rdata        (io_rdata),
        .regif_wb_enable (regif_wb_enable),
        .regif_wb_reg    (regif_wb_reg),
        .regif_wb_data   (regif_wb_data),
        .df_wb_enable    (df_wb_enable),
        .df_wb_reg       (df_wb_reg),
        .df_wb_data      (df_wb_data),
        .instret_count   (instret_count)
    );

    rv32i_wb_top #(.RESET_PC(32'h0000_0100), .INSTRET_W(3)) dut_small (
        .clk             (clk),
        .reset           (reset),
        .stall_in        (stall_in),
        .valid_in        (valid_in),
        .pc_in           (pc_in),
        .iw_in           (iw_in),
        .alu_in          (alu_in),
        .wb_reg_in       (wb_reg_in),
        .wb_en_in        (wb_en_in),
        .src_sel_in      (src_sel_in),
        .memif_rdata     (memif_rdata),
        .io_rdata        (io_rdata),
        .regif_wb_enable (s_regif_wb_enable),
        .regif_wb_reg    (s_regif_wb_reg),
        .regif_wb_data   (s_regif_wb_data),
        .df_wb_enable    (s_df_wb_enable),
        .df_wb_reg       (s_df_wb_reg),
        .df_wb_data      (s_df_wb_data),
        .instret_count   (s_instret_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] iw,
                         input logic [31:0] alu, input logic [4:0] rd, input logic wen,
                         input logic [1:0] src);
        valid_in   = v;
        pc_in      = pc;
        iw_in      = iw;
        alu_in     = alu;
        wb_reg_in  = rd;
        wb_en_in   = wen;
        src_sel_in = src;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic en, input logic [4:0] rd,
                          input logic [31:0] data);
        chk({tag, ".en"},      {63'h0, regif_wb_enable}, {63'h0, en});
        chk({tag, ".reg"},     {59'h0, regif_wb_reg},    {59'h0, rd});
        chk({tag, ".data"},    {32'h0, regif_wb_data},   {32'h0, data});
        chk({tag, ".df_en"},   {63'h0, df_wb_enable},    {63'h0, en});
        chk({tag, ".df_reg"},  {59'h0, df_wb_reg},       {59'h0, rd});
        chk({tag, ".df_data"}, {32'h0, df_wb_data},      {32'h0, data});
    endtask

    initial begin
        reset       = 1'b1;
        stall_in    = 1'b0;
        memif_rdata = 32'h0;
        io_rdata    = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0);
        step();
        step();
        reset = 1'b0;

        chk_wb("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.instret", instret_count, 64'd0);
        chk("reset.pc_q", {32'h0, dut.pc_q}, 64'h100);

        // ALU writeback
        drive(1'b1, 32'h0000_1000, 32'h0000_0033, 32'h1234_5678, 5'd5, 1'b1, 2'd0);
        step();
        chk_wb("alu", 1'b1, 5'd5, 32'h1234_5678);
        chk("alu.instret", instret_count, 64'd0);

        // loads from RAM; IO word differs so a wrong mux leg is visible
        memif_rdata = 32'h80FF_7F01;
        io_rdata    = 32'h1111_1111;
        drive(1'b1, 32'h0000_1004, 32'h0000_0003, 32'h0000_1003, 5'd6, 1'b1, 2'd1);
        step();
        chk_wb("lb_off3", 1'b1, 5'd6, 32'hFFFF_FF80);
        chk("lb.instret", instret_count, 64'd1);

        drive(1'b1, 32'h0000_1008, 32'h0000_4003, 32'h0000_1002, 5'd6, 1'b1, 2'd1);
        step();
        chk_wb("lbu_off2", 1'b1, 5'd6, 32'h0000_00FF);

        drive(1'b1, 32'h0000_100C, 32'h0000_1003, 32'h0000_1002, 5'd6, 1'b1, 2'd1);
        step();
        chk_wb("lh_off2", 1'b1, 5'd6, 32'hFFFF_80FF);

        drive(1'b1, 32'h0000_1010, 32'h0000_5003, 32'h0000_1000, 5'd6, 1'b1, 2'd1);
        step();
        chk_wb("lhu_off0", 1'b1, 5'd6, 32'h0000_7F01);
        chk("lhu.instret", instret_count, 64'd4);

        drive(1'b1, 32'h0000_1014, 32'h0000_0003, 32'h0000_1001, 5'd6, 1'b1, 2'd1);
        step();
        chk_wb("lb_off1", 1'b1, 5'd6, 32'h0000_007F);

        // x0 destination: suppressed but still retired
        drive(1'b1, 32'h0000_1018, 32'h0000_0033, 32'h0000_AAAA, 5'd0, 1'b1, 2'd0);
        step();
        chk_wb("x0", 1'b0, 5'd0, 32'h0000_AAAA);
        chk("x0.instret", instret_count, 64'd6);

        // bubble: not written, not counted
        drive(1'b0, 32'h0000_101C, 32'h0000_0033, 32'h0000_0011, 5'd7, 1'b1, 2'd0);
        step();
        chk("bubble.en", {63'h0, regif_wb_enable}, 64'd0);
        chk("bubble.df_en", {63'h0, df_wb_enable}, 64'd0);
        chk("bubble.instret", instret_count, 64'd7);

        drive(1'b1, 32'h0000_1020, 32'h0000_0033, 32'h0000_0011, 5'd8, 1'b1, 2'd0);
        step();
        chk("after_bubble.instret", instret_count, 64'd7);

        // link wraps at 2^32
        drive(1'b1, 32'hFFFF_FFFC, 32'h0000_006F, 32'h0000_0000, 5'd1, 1'b1, 2'd3);
        step();
        chk_wb("link_wrap", 1'b1, 5'd1, 32'h0000_0000);

        drive(1'b1, 32'h0000_2000, 32'h0000_00EF, 32'h0000_0000, 5'd1, 1'b1, 2'd3);
        step();
        chk_wb("link", 1'b1, 5'd1, 32'h0000_2004);

        // IO loads
        io_rdata = 32'hDEAD_BEEF;
        drive(1'b1, 32'h0000_2004, 32'h0000_2003, 32'h0000_2000, 5'd9, 1'b1, 2'd2);
        step();
        chk_wb("io_lw", 1'b1, 5'd9, 32'hDEAD_BEEF);

        drive(1'b1, 32'h0000_2008, 32'h0000_4003, 32'h0000_2001, 5'd9, 1'b1, 2'd2);
        step();
        chk_wb("io_lbu_off1", 1'b1, 5'd9, 32'h0000_00BE);

        drive(1'b1, 32'h0000_200C, 32'h0000_1003, 32'h0000_2003, 5'd9, 1'b1, 2'd2);
        step();
        chk_wb("io_lh_off3", 1'b1, 5'd9, 32'hFFFF_DEAD);
        chk("io.instret", instret_count, 64'd12);

        // stall over a valid ADD: held three cycles, retired once
        drive(1'b1, 32'h0000_2010, 32'h0000_0033, 32'h0000_0055, 5'd10, 1'b1, 2'd0);
        step();
        chk_wb("stall_load", 1'b1, 5'd10, 32'h0000_0055);
        chk("stall_load.instret", instret_count, 64'd13);
        stall_in = 1'b1;
        drive(1'b1, 32'h0000_2014, 32'h0000_0033, 32'h0000_0066, 5'd11, 1'b1, 2'd0);
        step();
        chk_wb("stall1", 1'b1, 5'd10, 32'h0000_0055);
        chk("stall1.instret", instret_count, 64'd13);
        step();
        chk_wb("stall2", 1'b1, 5'd10, 32'h0000_0055);
        step();
        chk_wb("stall3", 1'b1, 5'd10, 32'h0000_0055);
        chk("stall3.instret", instret_count, 64'd13);
        stall_in = 1'b0;
        drive(1'b0, 32'h0000_2018, 32'h0000_0033, 32'h0000_0077, 5'd12, 1'b1, 2'd0);
        step();
        chk("unstall.en", {63'h0, regif_wb_enable}, 64'd0);
        chk("unstall.instret", instret_count, 64'd14);

        // reset wins over stall
        drive(1'b1, 32'h0000_201C, 32'h0000_0033, 32'h0000_0077, 5'd12, 1'b1, 2'd3);
        step();
        chk_wb("pre_reset", 1'b1, 5'd12, 32'h0000_2020);
        stall_in = 1'b1;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        stall_in = 1'b0;
        chk_wb("mid_reset", 1'b0, 5'd0, 32'h0);
        chk("mid_reset.instret", instret_count, 64'd0);
        chk("mid_reset.pc_q", {32'h0, dut.pc_q}, 64'h100);
        chk("mid_reset.small", {61'h0, s_instret_count}, 64'd0);

        // narrow counter: 7 -> 0 wrap
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h0000_3000 + 32'(i * 4), 32'h0000_0033, 32'(i), 5'd3, 1'b1, 2'd0);
            step();
        end
        chk("wrap.small_max", {61'h0, s_instret_count}, 64'd7);
        chk("wrap.wide", instret_count, 64'd7);
        step();
        chk("wrap.small_zero", {61'h0, s_instret_count}, 64'd0);
        chk("wrap.wide_next", instret_count, 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
